// File: rtl/data_mem_responder.sv
// Load/store data-memory target, one request at a time; DM_ERR_EN adds misalign/range errors on resp_err.
// Latency: accept at edge N -> resp_valid after edge N+LATENCY; one access per LATENCY+2 cycles back-to-back.
// Backpressure: req_ready low outside IDLE; response held stable until resp_ready.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [63:0] element1,
    output logic [63:0] element2,
    output logic [63:0] element3
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic        r_uns;
    logic [1:0]  r_size;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [63:0] r_rdata;
    logic        r_err;
    logic [63:0] r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic          w_commit;
    logic [AW-1:0] w_idx;
    logic [63:0]   w_word;
    logic [63:0]   w_shift;
    logic [63:0]   w_mask;
    logic [63:0]   w_field;
    logic [63:0]   w_load;
    logic [63:0]   w_wshift;
    logic [63:0]   w_new_word;
    logic [7:0]    w_bemask;
    logic [7:0]    w_be;
    logic [2:0]    w_align;
    logic          w_sign;
    logic          w_err;
    logic          w_unused;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_accept = (r_state == S_IDLE) && req_valid;
    assign w_commit = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_idx    = r_addr[AW+2:3];

    // Field extraction and byte enables are truncated at lane 7: no access spills into the next word.
    always_comb begin
        w_word   = r_mem[w_idx];
        w_shift  = w_word >> {r_addr[2:0], 3'b000};
        w_wshift = r_wdata << {r_addr[2:0], 3'b000};
        case (r_size)
            2'd0: begin
                w_mask = 64'h0000_0000_0000_00FF; w_sign = w_shift[7];
                w_bemask = 8'h01; w_align = 3'b000;
            end
            2'd1: begin
                w_mask = 64'h0000_0000_0000_FFFF; w_sign = w_shift[15];
                w_bemask = 8'h03; w_align = 3'b001;
            end
            2'd2: begin
                w_mask = 64'h0000_0000_FFFF_FFFF; w_sign = w_shift[31];
                w_bemask = 8'h0F; w_align = 3'b011;
            end
            default: begin
                w_mask = 64'hFFFF_FFFF_FFFF_FFFF; w_sign = w_shift[63];
                w_bemask = 8'hFF; w_align = 3'b111;
            end
        endcase
        w_field    = w_shift & w_mask;
        w_load     = (r_uns || !w_sign) ? w_field : (w_field | ~w_mask);
        w_be       = w_bemask << r_addr[2:0];
        w_new_word = w_word;
        for (int b = 0; b < 8; b++) begin
            if (w_be[b]) w_new_word[8*b +: 8] = w_wshift[8*b +: 8];
        end
    end

`ifdef DM_ERR_EN
    assign w_err = ((r_addr[2:0] & w_align) != 3'b000) || (|r_addr[63:AW+3]);
`else
    assign w_err = 1'b0;
`endif

    assign w_unused = ^{r_addr[63:AW+3], w_align};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= 64'd0;
            r_wdata <= 64'd0;
            r_rdata <= 64'd0;
            r_err   <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= 64'd0;
        end else begin
            if (w_accept) begin
                r_write <= req_write;
                r_uns   <= req_unsigned;
                r_size  <= req_size;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_cnt   <= 4'(LATENCY - 1);
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // The only point where memory changes; an access abandoned by reset leaves no trace.
            if (w_commit) begin
                r_rdata <= (r_write || w_err) ? 64'd0 : w_load;
                r_err   <= w_err;
                if (r_write && !w_err) r_mem[w_idx] <= w_new_word;
            end
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign element1   = r_mem[0];
    assign element2   = r_mem[1];
    assign element3   = r_mem[2];

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: stimulus pushes expected responses into a queue,
// a negedge monitor pops and compares on every resp handshake.
`timescale 1ns/1ps
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        resp_ready = 1'b1;
    logic        req_ready;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [63:0] element1, element2, element3;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

`ifdef DM_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .element1(element1), .element2(element2), .element3(element3)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got rdata 0x%h with no response expected", resp_rdata);
            end else begin
                e = exp_q.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err", {63'd0, resp_err}, {63'd0, e.err});
            end
        end
    end

    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wd,
                         input logic push, input logic [63:0] exp_rd, input logic exp_err);
        int n = 0;
        @(negedge clk);
        req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready=%0b after %0d cycles, required 1", req_ready, n);
            req_valid = 1'b0;
            return;
        end
        if (push) exp_q.push_back({exp_rd, exp_err});
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int cyc;
        int n;
        logic [63:0] ld;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        check("rst_resp_err", {63'd0, resp_err}, 64'd0);
        check("rst_element1", element1, 64'd0);
        check("rst_element2", element2, 64'd0);
        check("rst_element3", element3, 64'd0);
        reset = 1'b1;

        // Dword load of empty memory, latency measured from accept edge
        issue(1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 1'b1, 64'd0, 1'b0);
        cyc = 0;
        while (!resp_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency", 64'(cyc), 64'd2);
        drain();

        // Dword store then load; element2 changes only at the commit edge
        issue(1'b1, 2'd3, 1'b0, 64'h8, 64'h1122334455667788, 1'b1, 64'd0, 1'b0);
        @(posedge clk);
        #1 check("elem2_before_commit", element2, 64'd0);
        @(posedge clk);
        #1 check("store_resp_valid", {63'd0, resp_valid}, 64'd1);
        check("elem2_after_commit", element2, 64'h1122334455667788);
        drain();
        issue(1'b0, 2'd3, 1'b0, 64'h8, 64'd0, 1'b1, 64'h1122334455667788, 1'b0);
        drain();

        // Byte store with signed/unsigned byte loads and a dword view
        issue(1'b1, 2'd0, 1'b0, 64'h3, 64'h80, 1'b1, 64'd0, 1'b0);
        issue(1'b0, 2'd0, 1'b0, 64'h3, 64'd0, 1'b1, 64'hFFFFFFFFFFFFFF80, 1'b0);
        issue(1'b0, 2'd0, 1'b1, 64'h3, 64'd0, 1'b1, 64'h0000000000000080, 1'b0);
        issue(1'b0, 2'd3, 1'b0, 64'h0, 64'd0, 1'b1, 64'h0000000080000000, 1'b0);
        drain();
        check("elem1_byte", element1, 64'h0000000080000000);

        // Half store, then a word load held off by resp_ready
        issue(1'b1, 2'd1, 1'b0, 64'h16, 64'h000000000000BEEF, 1'b1, 64'd0, 1'b0);
        drain();
        check("elem3_half", element3, 64'hBEEF000000000000);
        resp_ready = 1'b0;
        issue(1'b0, 2'd2, 1'b0, 64'h14, 64'd0, 1'b1, 64'hFFFFFFFFBEEF0000, 1'b0);
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stall_resp_valid_seen", {63'd0, resp_valid}, 64'd1);
        req_write = 1'b1; req_size = 2'd3; req_unsigned = 1'b0;
        req_addr = 64'h0; req_wdata = 64'hFFFFFFFFFFFFFFFF; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_resp_valid", {63'd0, resp_valid}, 64'd1);
            check("stall_resp_rdata", resp_rdata, 64'hFFFFFFFFBEEF0000);
            check("stall_req_ready", {63'd0, req_ready}, 64'd0);
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("post_hs_req_ready", {63'd0, req_ready}, 64'd1);
        check("post_hs_resp_valid", {63'd0, resp_valid}, 64'd0);
        repeat (4) @(negedge clk);
        check("ignored_store_elem1", element1, 64'h0000000080000000);
        check("queue_empty_after_stall", 64'(exp_q.size()), 64'd0);

        // Reset while a store waits: no response, state back to IDLE
        issue(1'b1, 2'd3, 1'b0, 64'h0, 64'h000000000000AAAA, 1'b0, 64'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_elem1", element1, 64'd0);
        check("midrst_req_ready", {63'd0, req_ready}, 64'd1);
        check("midrst_resp_valid", {63'd0, resp_valid}, 64'd0);
        repeat (4) @(negedge clk);
        check("midrst_no_resp", {63'd0, resp_valid}, 64'd0);

        // Out-of-range store and misaligned loads
        issue(1'b1, 2'd3, 1'b0, 64'h200, 64'h0000000012345A5A, 1'b1, 64'd0, ERR);
        drain();
        check("oor_store_elem1", element1, ERR ? 64'd0 : 64'h0000000012345A5A);
        issue(1'b0, 2'd2, 1'b0, 64'h2, 64'd0, 1'b1, ERR ? 64'd0 : 64'h0000000000001234, ERR);
        issue(1'b0, 2'd3, 1'b0, 64'h2, 64'd0, 1'b1, ERR ? 64'd0 : 64'h0000000000001234, ERR);
        ld = ERR ? 64'd0 : 64'h000000000012345A;
        issue(1'b0, 2'd2, 1'b1, 64'h1, 64'd0, 1'b1, ld, ERR);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
